// File: rtl/rf_pkg.sv
// Shared constants and types for the register file.
package rf_pkg;
  localparam int WORD           = 8;
  localparam int DEF_WIDTH      = 4 * WORD;
  localparam int DEF_ADDR_SPACE = 5;
  localparam int DEF_REG_AMOUNT = 32;
  localparam logic [DEF_ADDR_SPACE-1:0] DEF_ZERO_REGISTER = 5'b00000;

  typedef logic [DEF_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: decode, zero/out-of-range masking, optional
// write bypass (enabled by defining RF_WRITE_BYPASS_EN).
module rf_read_port import rf_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_SPACE = DEF_ADDR_SPACE,
  parameter int REG_AMOUNT = DEF_REG_AMOUNT,
  parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = ADDR_SPACE'(DEF_ZERO_REGISTER)
) (
  input  logic [REG_AMOUNT-1:0][WIDTH-1:0] regs_i,
  input  logic [ADDR_SPACE-1:0]            addr_i,
  input  logic                             wr_ok_i,
  input  logic [ADDR_SPACE-1:0]            wr_addr_i,
  input  logic [WIDTH-1:0]                 wr_data_i,
  output logic [WIDTH-1:0]                 data_o
);

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Unmatched addresses (zero register, >= REG_AMOUNT) fall through to 0.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < REG_AMOUNT; i++)
      if (addr_i == ADDR_SPACE'(i) && ADDR_SPACE'(i) != ZERO_REGISTER)
        data_o = regs_i[i];
    // wr_ok_i already excludes the zero register and out-of-range addresses.
    if (BYPASS && wr_ok_i && wr_addr_i == addr_i)
      data_o = wr_data_i;
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with hardwired zero register.
// Define RF_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file import rf_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_SPACE = DEF_ADDR_SPACE,
  parameter int REG_AMOUNT = DEF_REG_AMOUNT,
  parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = ADDR_SPACE'(DEF_ZERO_REGISTER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_SPACE-1:0] r1_addr,
  input  logic [ADDR_SPACE-1:0] r2_addr,
  input  logic [ADDR_SPACE-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      r1,
  output logic [WIDTH-1:0]      r2
);

  logic [REG_AMOUNT-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                             wr_ok;

  assign wr_ok = wr_en && !rst && (wr_addr != ZERO_REGISTER) &&
                 (32'(wr_addr) < 32'(REG_AMOUNT));

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < REG_AMOUNT; i++)
      if (wr_ok && wr_addr == ADDR_SPACE'(i))
        regs_d[i] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  rf_read_port #(
    .WIDTH(WIDTH), .ADDR_SPACE(ADDR_SPACE), .REG_AMOUNT(REG_AMOUNT), .ZERO_REGISTER(ZERO_REGISTER)
  ) u_rd1 (
    .regs_i(regs_q), .addr_i(r1_addr), .wr_ok_i(wr_ok),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .data_o(r1)
  );

  rf_read_port #(
    .WIDTH(WIDTH), .ADDR_SPACE(ADDR_SPACE), .REG_AMOUNT(REG_AMOUNT), .ZERO_REGISTER(ZERO_REGISTER)
  ) u_rd2 (
    .regs_i(regs_q), .addr_i(r2_addr), .wr_ok_i(wr_ok),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .data_o(r2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed scoreboard bench: a default instance plus a small one
// (20 registers, zero register at 31) sharing the same stimulus.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  r1_addr, r2_addr, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] r1, r2, s_r1, s_r2;

  always #5 clk = ~clk;

  register_file u_dut (
    .clk(clk), .rst(rst), .r1_addr(r1_addr), .r2_addr(r2_addr), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .r1(r1), .r2(r2)
  );

  register_file #(.REG_AMOUNT(20), .ZERO_REGISTER(5'd31)) u_small (
    .clk(clk), .rst(rst), .r1_addr(r1_addr), .r2_addr(r2_addr), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .r1(s_r1), .r2(s_r2)
  );

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          port;   // 0:r1 1:r2 2:s_r1 3:s_r2
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.port = port; e.exp = exp;
    exp_q.push_back(e);
  endtask

  // Outputs are combinational; let them settle before popping.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.port)
        0:       obs = r1;
        1:       obs = r2;
        2:       obs = s_r1;
        default: obs = s_r2;
      endcase
      n_cmp++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
    wr_addr = a; wr_data = d; wr_en = en;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; r1_addr = '0; r2_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset sweep: everything reads zero
    for (int i = 0; i < 32; i++) begin
      r1_addr = 5'(i); r2_addr = 5'(31 - i);
      push($sformatf("rst_r1_%0d", i), 0, 32'h0);
      push($sformatf("rst_r2_%0d", 31 - i), 1, 32'h0);
      push($sformatf("rst_small_%0d", i), 2, 32'h0);
      drain();
    end

    // First edge after reset accepts a write
    r1_addr = 5'd3;
    wr(5'd3, 32'd7, 1'b1);
    push("wr3", 0, 32'd7); push("wr3_small", 2, 32'd7); drain();

    // Zero register ignores writes; small instance treats addr 0 as normal
    r1_addr = 5'd0; r2_addr = 5'd0;
    wr(5'd0, 32'd59, 1'b1);
    push("zero_r1", 0, 32'h0); push("zero_r2", 1, 32'h0); push("small_reg0", 2, 32'd59); drain();

    // wr_en=0 leaves register untouched, then real write
    r1_addr = 5'd7; r2_addr = 5'd7;
    wr(5'd7, 32'd59, 1'b0);
    push("noen_r1", 0, 32'h0); push("noen_r2", 1, 32'h0); drain();
    wr(5'd7, 32'd59, 1'b1);
    push("wr7_r1", 0, 32'd59); push("wr7_r2", 1, 32'd59); drain();

    // Out-of-range on small instance; normal on default instance
    r1_addr = 5'd25;
    wr(5'd25, 32'h0000_00AA, 1'b1);
    push("wr25", 0, 32'hAA); push("oor_small", 2, 32'h0); drain();
    r1_addr = 5'd31;
    wr(5'd31, 32'h0000_00BB, 1'b1);
    push("wr31", 0, 32'hBB); push("small_zero31", 2, 32'h0); drain();
    r1_addr = 5'd19; r2_addr = 5'd19;
    wr(5'd19, 32'h0000_0077, 1'b1);
    push("last_r1_small", 2, 32'h77); push("last_r2_small", 3, 32'h77); push("wr19", 0, 32'h77); drain();

    // Reset beats a simultaneous write and clears everything
    rst = 1'b1; r1_addr = 5'd5; r2_addr = 5'd7;
    wr(5'd5, 32'hDEAD_BEEF, 1'b1);
    rst = 1'b0;
    push("rstwr_r1", 0, 32'h0); push("rst_clr7", 1, 32'h0); push("rst_small19", 3, 32'h77 & 32'h0); drain();
    r2_addr = 5'd19;
    push("rst_clr19_small", 3, 32'h0); drain();

    // Same-cycle read of the address being written
    r1_addr = 5'd9; r2_addr = 5'd9;
    wr_addr = 5'd9; wr_data = 32'h1234; wr_en = 1'b1;
    push("byp_r1", 0, BYP ? 32'h1234 : 32'h0);
    push("byp_r2", 1, BYP ? 32'h1234 : 32'h0);
    push("byp_small", 2, BYP ? 32'h1234 : 32'h0);
    drain();
    tick();
    wr_en = 1'b0;
    push("post_r1", 0, 32'h1234); push("post_r2", 1, 32'h1234); drain();

    // No forwarding for the zero register or out-of-range writes
    r1_addr = 5'd0; r2_addr = 5'd25;
    wr_addr = 5'd0; wr_data = 32'hCC; wr_en = 1'b1;
    push("byp_zero", 0, 32'h0); push("byp_small0", 2, BYP ? 32'hCC : 32'h0); drain();
    wr_addr = 5'd25;
    push("byp_oor_small", 3, 32'h0); push("byp_25", 1, BYP ? 32'hCC : 32'h0); drain();
    wr_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
